// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARM-subset pipeline stages.
// The IF/ID bundle is the register handed from fetch to decode.
package arm_pipe_pkg;

    localparam int INSTR_W = 32;
    localparam logic [31:0] PC_INCR = 32'd4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
        logic               valid;
    } if_id_t;

    // Branch targets are word addresses; low bits are dropped, not trapped.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/instruction_memory.sv
// Word-addressed instruction ROM with a combinational read port.
// Words beyond IMEM_DEPTH read back as NOP_INSTR.
module instruction_memory
    import arm_pipe_pkg::*;
#(
    parameter int                 IMEM_DEPTH = 1024,
    parameter string              IMEM_FILE  = "imem.hex",
    parameter logic [INSTR_W-1:0] NOP_WORD   = arm_pipe_pkg::NOP_INSTR
) (
    input  logic [29:0]        word_addr,
    output logic [INSTR_W-1:0] rdata
);

    localparam int AW = $clog2(IMEM_DEPTH);

    logic [INSTR_W-1:0] mem [IMEM_DEPTH];
    logic               in_range;

    assign in_range = (word_addr[29:AW] == '0);

    always_comb begin
        rdata = NOP_WORD;
        if (in_range) begin
            rdata = mem[word_addr[AW-1:0]];
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC mux and IF/ID register.
// Define IF_PERF_CNT_EN to add fetch/stall/flush event counters.
module if_stage
    import arm_pipe_pkg::*;
#(
    parameter int                 IMEM_DEPTH = 1024,
    parameter logic [31:0]        RESET_PC   = 32'h0000_0000,
    parameter logic [INSTR_W-1:0] NOP_INSTR  = arm_pipe_pkg::NOP_INSTR,
    parameter string              IMEM_FILE  = "imem.hex"
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branch_taken,
    input  logic [31:0]        branch_addr,
    output logic [31:0]        pc_out,
    output logic [INSTR_W-1:0] instruction,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]        fetch_cnt,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        flush_cnt,
`endif
    output logic               valid
);

    logic [31:0]        pc_reg;
    logic [31:0]        pc_next;
    logic [31:0]        pc_incr;
    logic [INSTR_W-1:0] fetch_word;
    if_id_t             if_id_reg;
    if_id_t             if_id_next;

    instruction_memory #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .IMEM_FILE  (IMEM_FILE),
        .NOP_WORD   (NOP_INSTR)
    ) u_imem (
        .word_addr (pc_reg[31:2]),
        .rdata     (fetch_word)
    );

    // Modulo-2^32 increment: the top word wraps to address 0.
    assign pc_incr = pc_reg + PC_INCR;

    always_comb begin
        pc_next    = pc_reg;
        if_id_next = if_id_reg;
        if (branch_taken) begin
            pc_next          = align_word(branch_addr);
            if_id_next.pc    = '0;
            if_id_next.instr = NOP_INSTR;
            if_id_next.valid = 1'b0;
        end else if (!freeze) begin
            pc_next          = pc_incr;
            if_id_next.pc    = pc_incr;
            if_id_next.instr = fetch_word;
            if_id_next.valid = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg          <= RESET_PC;
            if_id_reg.pc    <= '0;
            if_id_reg.instr <= NOP_INSTR;
            if_id_reg.valid <= 1'b0;
        end else begin
            pc_reg    <= pc_next;
            if_id_reg <= if_id_next;
        end
    end

    assign pc_out      = if_id_reg.pc;
    assign instruction = if_id_reg.instr;
    assign valid       = if_id_reg.valid;

`ifdef IF_PERF_CNT_EN
    // Counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (branch_taken) begin
            if (flush_cnt != '1) flush_cnt <= flush_cnt + 32'd1;
        end else if (freeze) begin
            if (stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
        end else begin
            if (fetch_cnt != '1) fetch_cnt <= fetch_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a reference fetch model pushes the expected
// IF/ID contents per edge; each scenario task pops and compares after the edge.
module tb_if_stage;

    localparam int          DEPTH = 64;
    localparam logic [31:0] NOP   = 32'hE1A0_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic [31:0] pc_out, instruction;
    logic        valid;
    logic [31:0] pc_out2, instruction2;
    logic        valid2;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt, stall_cnt, flush_cnt;
    logic [31:0] fetch_cnt2, stall_cnt2, flush_cnt2;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] rom_m [DEPTH];
    logic [31:0] pc_m;
    exp_t        exp_m;
    exp_t        sb_q [$];
    int          fetch_m, stall_m, flush_m;

    if_stage #(
        .IMEM_DEPTH (DEPTH),
        .RESET_PC   (32'h0000_0000),
        .NOP_INSTR  (NOP),
        .IMEM_FILE  ("imem.hex")
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .pc_out       (pc_out),
        .instruction  (instruction),
`ifdef IF_PERF_CNT_EN
        .fetch_cnt    (fetch_cnt),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
`endif
        .valid        (valid)
    );

    if_stage #(
        .IMEM_DEPTH (DEPTH),
        .RESET_PC   (32'hFFFF_FFFC),
        .NOP_INSTR  (NOP),
        .IMEM_FILE  ("imem.hex")
    ) dut2 (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .pc_out       (pc_out2),
        .instruction  (instruction2),
`ifdef IF_PERF_CNT_EN
        .fetch_cnt    (fetch_cnt2),
        .stall_cnt    (stall_cnt2),
        .flush_cnt    (flush_cnt2),
`endif
        .valid        (valid2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_read(input logic [31:0] pc);
        if (pc[31:2] < DEPTH) return rom_m[pc[7:2]];
        return NOP;
    endfunction

    // Apply one cycle of inputs, predict the IF/ID result, advance past the edge.
    task automatic drive(input logic f, input logic b, input logic [31:0] a);
        freeze       = f;
        branch_taken = b;
        branch_addr  = a;
        if (b) begin
            pc_m        = {a[31:2], 2'b00};
            exp_m.pc    = 32'h0;
            exp_m.instr = NOP;
            exp_m.valid = 1'b0;
            flush_m++;
        end else if (f) begin
            stall_m++;
        end else begin
            exp_m.pc    = pc_m + 32'd4;
            exp_m.instr = rom_read(pc_m);
            exp_m.valid = 1'b1;
            pc_m        = pc_m + 32'd4;
            fetch_m++;
        end
        sb_q.push_back(exp_m);
        @(posedge clk);
        #1;
    endtask

    task automatic assert_reset();
        #2;
        rst = 1'b0;
        #1;
        sb_q.delete();
        pc_m        = 32'h0;
        exp_m.pc    = 32'h0;
        exp_m.instr = NOP;
        exp_m.valid = 1'b0;
        fetch_m = 0; stall_m = 0; flush_m = 0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst          = 1'b1;
        freeze       = 1'b0;
        branch_taken = 1'b0;
    endtask

    task automatic test_reset();
        assert_reset();
        checks++;
        if (pc_out !== 32'h0 || instruction !== NOP || valid !== 1'b0) begin
            errors++;
            $display("FAIL reset: got (%h,%h,%b) want (00000000,%h,0)", pc_out, instruction, valid, NOP);
        end
        checks++;
        if (pc_out2 !== 32'h0 || instruction2 !== NOP || valid2 !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut2: got (%h,%h,%b) want (00000000,%h,0)", pc_out2, instruction2, valid2, NOP);
        end
        release_reset();
    endtask

    task automatic test_fetch(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 1'b0, 32'h0);
            e = sb_q.pop_front();
            checks++;
            if (pc_out !== e.pc || instruction !== e.instr || valid !== e.valid) begin
                errors++;
                $display("FAIL fetch[%0d]: got (%h,%h,%b) want (%h,%h,%b)", i, pc_out, instruction, valid, e.pc, e.instr, e.valid);
            end
        end
    endtask

    task automatic test_freeze(input int n);
        exp_t e;
        for (int i = 0; i <= n; i++) begin
            drive(i < n, 1'b0, 32'h0);
            e = sb_q.pop_front();
            checks++;
            if (pc_out !== e.pc || instruction !== e.instr || valid !== e.valid) begin
                errors++;
                $display("FAIL freeze[%0d]: got (%h,%h,%b) want (%h,%h,%b)", i, pc_out, instruction, valid, e.pc, e.instr, e.valid);
            end
        end
    endtask

    task automatic test_branch(input logic [31:0] target, input logic with_freeze, input int n_after);
        exp_t e;
        for (int i = 0; i <= n_after; i++) begin
            if (i == 0) drive(with_freeze, 1'b1, target);
            else        drive(1'b0, 1'b0, 32'h0);
            e = sb_q.pop_front();
            checks++;
            if (pc_out !== e.pc || instruction !== e.instr || valid !== e.valid) begin
                errors++;
                $display("FAIL branch_%h[%0d]: got (%h,%h,%b) want (%h,%h,%b)", target, i, pc_out, instruction, valid, e.pc, e.instr, e.valid);
            end
        end
    endtask

    task automatic test_back_to_back(input int n);
        exp_t        e;
        logic        f, b;
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            f = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 7) == 0);
            a = 32'($urandom_range(0, 80)) * 32'd4 + 32'($urandom_range(0, 3));
            drive(f, b, a);
            e = sb_q.pop_front();
            checks++;
            if (pc_out !== e.pc || instruction !== e.instr || valid !== e.valid) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got (%h,%h,%b) want (%h,%h,%b)", i, pc_out, instruction, valid, e.pc, e.instr, e.valid);
            end
        end
    endtask

    task automatic test_reset_pc();
        exp_t e;
        assert_reset();
        release_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'h0);
            e = sb_q.pop_front();
            checks++;
            if (pc_out !== e.pc || instruction !== e.instr || valid !== e.valid) begin
                errors++;
                $display("FAIL reset_pc_dut[%0d]: got (%h,%h,%b) want (%h,%h,%b)", i, pc_out, instruction, valid, e.pc, e.instr, e.valid);
            end
            // dut2 starts at the top word: NOP at pc_out 0, then ROM from word 0.
            checks++;
            if (pc_out2 !== 32'(i) * 32'd4 || instruction2 !== (i == 0 ? NOP : rom_m[i-1]) || valid2 !== 1'b1) begin
                errors++;
                $display("FAIL reset_pc_dut2[%0d]: got (%h,%h,%b) want (%h,%h,1)", i, pc_out2, instruction2, valid2,
                         32'(i) * 32'd4, (i == 0 ? NOP : rom_m[i-1]));
            end
        end
    endtask

    task automatic test_perf_counters();
`ifdef IF_PERF_CNT_EN
        checks++;
        if (fetch_cnt !== 32'(fetch_m) || stall_cnt !== 32'(stall_m) || flush_cnt !== 32'(flush_m)) begin
            errors++;
            $display("FAIL perf_cnt: got fetch=%0d stall=%0d flush=%0d want fetch=%0d stall=%0d flush=%0d",
                     fetch_cnt, stall_cnt, flush_cnt, fetch_m, stall_m, flush_m);
        end
`endif
    endtask

    task automatic test_async_reset_mid_freeze();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 1'b0, 32'h0);
            e = sb_q.pop_front();
            checks++;
            if (pc_out !== e.pc || instruction !== e.instr || valid !== e.valid) begin
                errors++;
                $display("FAIL pre_reset_freeze[%0d]: got (%h,%h,%b) want (%h,%h,%b)", i, pc_out, instruction, valid, e.pc, e.instr, e.valid);
            end
        end
        assert_reset();
        checks++;
        if (pc_out !== 32'h0 || instruction !== NOP || valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_freeze: got (%h,%h,%b) want (00000000,%h,0)", pc_out, instruction, valid, NOP);
        end
`ifdef IF_PERF_CNT_EN
        checks++;
        if (fetch_cnt !== 32'h0 || stall_cnt !== 32'h0 || flush_cnt !== 32'h0) begin
            errors++;
            $display("FAIL async_reset_cnt: got fetch=%0d stall=%0d flush=%0d want 0 0 0", fetch_cnt, stall_cnt, flush_cnt);
        end
`endif
        release_reset();
        test_fetch(2);
    endtask

    initial begin
        rst          = 1'b1;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'h0;
        #1;
        rom_m[0] = 32'hA000_000A;
        rom_m[1] = 32'hB000_000B;
        rom_m[2] = 32'hC000_000C;
        rom_m[3] = 32'hD000_000D;
        for (int i = 4; i < DEPTH; i++) rom_m[i] = $urandom;
        for (int i = 0; i < DEPTH; i++) begin
            dut.u_imem.mem[i]  = rom_m[i];
            dut2.u_imem.mem[i] = rom_m[i];
        end

        test_reset();
        test_fetch(2);
        test_freeze(3);
        test_fetch(1);
        test_branch(32'h0000_0040, 1'b0, 3);
        test_branch(32'h0000_0023, 1'b1, 2);
        test_branch(32'h0000_00F8, 1'b0, 4);
        test_branch(32'hFFFF_FFFE, 1'b0, 3);
        test_back_to_back(60);
        test_perf_counters();
        test_reset_pc();
        test_async_reset_mid_freeze();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
